fall_step_timer: RTL and testbench
==================================

Name: fall_step_timer

Overview:
- Consumes the fall-period word (cycles per note step, 25 MHz domain) from the clock divider and turns it into single-cycle step ticks for the note-fall logic.
- Tracks the current falling row, supports pause/hold, and applies period changes from difficulty updates only at step boundaries.
- Sits between the clock divider and the note-field/playfield update logic.

Parameters:
- CNT_W, 32, width of period input and interval counter
- ROWS, 16, number of playfield rows; row index wraps at ROWS-1
- ROW_W, 4, width of row output; must satisfy 2^ROW_W >= ROWS
- MIN_PERIOD, 1000, lower clamp on the accepted period, in cycles

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  synchronous reset, active-high
- period_in  in  CNT_W  requested cycles per step (from divider)
- start  in  1  pulse: begin stepping from IDLE
- stop  in  1  pulse: abort to IDLE
- pause  in  1  level: freeze stepping while high
- tick  out  1  one-cycle pulse per elapsed step
- row  out  ROW_W  current fall row, 0..ROWS-1
- frame_done  out  1  one-cycle pulse when row wraps ROWS-1 -> 0
- period_act  out  CNT_W  period currently in force
- busy  out  1  high in RUN or HOLD

Behaviour:
- Reset values: state=IDLE, cnt=0, tick=0, row=0, frame_done=0, period_act=MIN_PERIOD, busy=0.
- Interface: one clock; reset is synchronous and active-high.
- Clamp rule: eff = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in. Unsigned compare, full CNT_W width.
- States:
  - IDLE: cnt=0, row=0. On start with stop=0: latch period_act=eff, cnt=0, go to RUN. Start with stop in the same cycle: stop wins, stay IDLE.
  - RUN:
    - Each cycle, cnt increments.
    - When cnt == period_act-1: cnt <= 0 and tick=1 on the next cycle (registered output).
    - Same edge: row <= (row==ROWS-1) ? 0 : row+1, and period_act <= eff (re-sampled only here).
    - frame_done=1 in the same cycle as the tick that wraps row to 0.
    - pause=1 -> HOLD, with cnt frozen. If the pause cycle is also the terminal count, the tick still completes first, then HOLD.
  - HOLD: cnt, row and period_act frozen; tick=0. pause=0 -> RUN, counting resumes from the frozen cnt with no lost or extra cycles.
  - stop in RUN or HOLD: next cycle IDLE, cnt=0, row=0, tick=0, frame_done=0; a tick pending in that cycle is suppressed.
- start while in RUN/HOLD: ignored.
- Latency: first tick asserts exactly period_act cycles after the start cycle. Subsequent ticks are period_act cycles apart, excluding HOLD cycles.
- Mid-interval period_in changes have no effect until the next tick boundary.
- busy = (state != IDLE), registered.
- rst asserted at any time, including mid-interval or in HOLD: all outputs return to reset values next cycle.

Optional Feature:
- Macro FALL_STEP_TOTAL_EN.
- Defined: adds output step_total [15:0], reset 0.
  - Increments on every tick and saturates at 16'hFFFF.
  - Cleared on rst only; not cleared on stop, so it spans multiple runs for scoring statistics.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- MIN_PERIOD=4, period_in=10, start pulse at cycle 0 -> tick at cycles 10, 20, 30; row reads 1, 2, 3 after each.
- period_in=2 (below clamp), start -> period_act=4, ticks every 4 cycles.
- ROWS=16, period 10, run 16 ticks -> 16th tick has frame_done=1 and row=0; no frame_done on other ticks.
- Run period 10, pause high for 7 cycles at cnt=5 -> next tick delayed by exactly 7 cycles, row unchanged during HOLD, busy=1 throughout.
- Change period_in 10 -> 20 at cnt=3 -> current interval still 10 cycles, next interval 20; period_act updates at that tick.
- start and stop together in IDLE -> stays IDLE, busy=0. stop at cnt=9 of period 10 -> no tick, row=0. rst in HOLD -> all outputs at reset values next cycle. With FALL_STEP_TOTAL_EN: step_total counts 3 ticks, then 2 after stop/start -> reads 5.

Source files
------------

// File: rtl/fall_step_timer.sv
// Step-tick generator for the note-fall logic: counts period_act cycles per step, tracks the falling row.
// Define FALL_STEP_TOTAL_EN to add the saturating step_total tick counter output.
module fall_step_timer #(
    parameter int CNT_W      = 32,
    parameter int ROWS       = 16,
    parameter int ROW_W      = 4,
    parameter int MIN_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period_in,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic             tick,
    output logic [ROW_W-1:0] row,
    output logic             frame_done,
    output logic [CNT_W-1:0] period_act,
    output logic             busy,
`ifdef FALL_STEP_TOTAL_EN
    output logic [15:0]      step_total,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] eff;
    logic             active;
    logic             at_term;

    assign eff       = (period_in < MIN_P) ? MIN_P : period_in;
    assign state_dbg = state;

    // HOLD with pause released counts on that very edge, so only edges that
    // sample pause=1 are lost and a pause of N cycles delays the tick by N.
    always_comb begin
        active     = 1'b0;
        at_term    = 1'b0;
        cnt_next   = cnt;
        state_next = state;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start && !stop) state_next = RUN;
            end
            RUN, HOLD: begin
                active  = (state == RUN) || !pause;
                at_term = active && (cnt == period_act - CNT_ONE);
                if (at_term)
                    cnt_next = '0;
                else if (active && !pause)
                    cnt_next = cnt + CNT_ONE;
                if (stop) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (pause) begin
                    state_next = HOLD;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tick       <= 1'b0;
            row        <= '0;
            frame_done <= 1'b0;
            period_act <= MIN_P;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            busy       <= (state_next != IDLE);
            tick       <= 1'b0;
            frame_done <= 1'b0;
            if (state == IDLE) begin
                row <= '0;
                if (start && !stop) period_act <= eff;
            end else if (stop) begin
                row <= '0;
            end else if (at_term) begin
                tick       <= 1'b1;
                frame_done <= (row == ROW_LAST);
                row        <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                period_act <= eff;
            end
        end
    end

`ifdef FALL_STEP_TOTAL_EN
    // Spans runs: only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)
            step_total <= 16'h0000;
        else if (at_term && !stop && (step_total != 16'hFFFF))
            step_total <= step_total + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_fall_step_timer.sv
// Self-checking bench for fall_step_timer; ticks are matched against an expected queue
// of {edge, frame_done, row} entries pushed when each run is started.
module tb_fall_step_timer;

    localparam int CNT_W = 32;
    localparam int ROW_W = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] period_in;
    logic             start;
    logic             stop;
    logic             pause;
    logic             tick;
    logic [ROW_W-1:0] row;
    logic             frame_done;
    logic [CNT_W-1:0] period_act;
    logic             busy;
    logic [1:0]       state_dbg;
`ifdef FALL_STEP_TOTAL_EN
    logic [15:0]      step_total;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int ecount = 0;
    logic [36:0] exp_q[$];

    fall_step_timer #(
        .CNT_W(CNT_W), .ROWS(16), .ROW_W(ROW_W), .MIN_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .period_in(period_in), .start(start), .stop(stop),
        .pause(pause), .tick(tick), .row(row), .frame_done(frame_done),
        .period_act(period_act), .busy(busy),
`ifdef FALL_STEP_TOTAL_EN
        .step_total(step_total),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            logic [36:0] o;
            logic [36:0] e;
            o = {32'(ecount), frame_done, row};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick: got tick at edge %0d row %0d fd %0b, required no tick",
                         ecount, row, frame_done);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL tick_match: got edge %0d fd %0b row %0d, required edge %0d fd %0b row %0d",
                             o[36:5], o[4], o[3:0], e[36:5], e[4], e[3:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ticks(input int s, input int p, input int n);
        for (int k = 1; k <= n; k++)
            exp_q.push_back({32'(s + p * k), 1'(k % 16 == 0), 4'(k % 16)});
    endtask

    // Pulses start; returns the posedge index that samples it.
    task automatic do_start(output int s);
        s = ecount + 1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_cmp++; if (row !== 4'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", row); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        n_cmp++; if (period_act !== 32'd4) begin n_fail++; $display("FAIL reset_period: got %0d want 4", period_act); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef FALL_STEP_TOTAL_EN
        n_cmp++; if (step_total !== 16'd0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", step_total); end
`endif
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic();
        int s;
        period_in = 32'd10;
        push_ticks(ecount + 1, 10, 3);
        do_start(s);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_cmp++; if (period_act !== 32'd10) begin n_fail++; $display("FAIL basic_period: got %0d want 10", period_act); end
        cyc(31);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (row !== 4'd3) begin n_fail++; $display("FAIL basic_row: got %0d want 3", row); end
        do_stop();
        n_cmp++; if (row !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_stop: got row %0d busy %b want 0 0", row, busy); end
    endtask

    task automatic test_clamp();
        int s;
        period_in = 32'd2;
        push_ticks(ecount + 1, 4, 3);
        do_start(s);
        n_cmp++; if (period_act !== 32'd4) begin n_fail++; $display("FAIL clamp_period: got %0d want 4", period_act); end
        cyc(13);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clamp_missing: got %0d pending want 0", exp_q.size()); end
        do_stop();
    endtask

    task automatic test_frame();
        int s;
        int p;
        p = $urandom_range(12, 5);
        period_in = 32'(p);
        push_ticks(ecount + 1, p, 16);
        do_start(s);
        cyc(16 * p + 1);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_missing: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (row !== 4'd0) begin n_fail++; $display("FAIL frame_row: got %0d want 0", row); end
        do_stop();
    endtask

    task automatic test_pause();
        int s;
        period_in = 32'd10;
        s = ecount + 1;
        exp_q.push_back({32'(s + 17), 1'b0, 4'd1});
        exp_q.push_back({32'(s + 27), 1'b0, 4'd2});
        do_start(s);
        cyc(5);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            n_cmp++;
            if (busy !== 1'b1 || row !== 4'd0 || state_dbg !== 2'd2) begin
                n_fail++;
                $display("FAIL pause_hold: got busy %b row %0d state %0d want 1 0 2", busy, row, state_dbg);
            end
        end
        pause = 1'b0;
        cyc(16);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pause_missing: got %0d pending want 0", exp_q.size()); end
        do_stop();
    endtask

    task automatic test_period_change();
        int s;
        period_in = 32'd10;
        s = ecount + 1;
        exp_q.push_back({32'(s + 10), 1'b0, 4'd1});
        exp_q.push_back({32'(s + 30), 1'b0, 4'd2});
        do_start(s);
        cyc(3);
        period_in = 32'd20;
        cyc(6);
        n_cmp++; if (period_act !== 32'd10) begin n_fail++; $display("FAIL chg_before: got %0d want 10", period_act); end
        cyc(1);
        n_cmp++; if (period_act !== 32'd20) begin n_fail++; $display("FAIL chg_after: got %0d want 20", period_act); end
        cyc(21);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL chg_missing: got %0d pending want 0", exp_q.size()); end
        do_stop();
    endtask

    task automatic test_start_stop_idle();
        period_in = 32'd10;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL ss_idle: got busy %b state %0d want 0 0", busy, state_dbg); end
        cyc(12);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_later: got busy %b want 0", busy); end
    endtask

    task automatic test_stop_terminal();
        int s;
        period_in = 32'd10;
        do_start(s);
        cyc(9);
        do_stop();
        n_cmp++;
        if (tick !== 1'b0 || row !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_term: got tick %b row %0d busy %b want 0 0 0", tick, row, busy);
        end
        cyc(15);
    endtask

    task automatic test_rst_hold();
        int s;
        period_in = 32'd10;
        exp_q.push_back({32'(ecount + 11), 1'b0, 4'd1});
        do_start(s);
        cyc(11);
        pause = 1'b1;
        cyc(3);
        n_cmp++; if (busy !== 1'b1 || row !== 4'd1) begin n_fail++; $display("FAIL rh_hold: got busy %b row %0d want 1 1", busy, row); end
        rst = 1'b1;
        cyc(1);
        n_cmp++;
        if (tick !== 1'b0 || row !== 4'd0 || frame_done !== 1'b0 || period_act !== 32'd4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rh_reset: got tick %b row %0d fd %b period %0d busy %b want 0 0 0 4 0",
                     tick, row, frame_done, period_act, busy);
        end
        rst   = 1'b0;
        pause = 1'b0;
        cyc(2);
    endtask

`ifdef FALL_STEP_TOTAL_EN
    task automatic test_step_total();
        int s;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        period_in = 32'd4;
        push_ticks(ecount + 1, 4, 3);
        do_start(s);
        cyc(13);
        do_stop();
        push_ticks(ecount + 1, 4, 2);
        do_start(s);
        cyc(9);
        do_stop();
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL total_missing: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (step_total !== 16'd5) begin n_fail++; $display("FAIL total_count: got %0d want 5", step_total); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        period_in = '0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
        cyc(1);
        test_reset();
        test_basic();
        test_clamp();
        test_frame();
        test_pause();
        test_period_change();
        test_start_stop_idle();
        test_stop_terminal();
        test_rst_hold();
`ifdef FALL_STEP_TOTAL_EN
        test_step_total();
`endif
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
